branch_unit: RTL and testbench
==============================

# branch_unit

Branch/jump resolution unit that drives the program counter's `absjump_en` and `target` inputs. It sits between instruction decode and the PC. It evaluates decoded control-flow ops against the ALU zero flag and encodes the destination as a 4-bit jump-LUT index in `target[D-1:D-4]`. A small return-index stack supports CALL/RET, and the unit squashes the one instruction fetched while a redirect is in flight.

## Interface
- `D`, 10: PC / target width; must be ≥ 5.
- `DEPTH`, 4: return-index stack entries; power of two, 2..16.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `op_valid`  in  1  decoded instruction valid this cycle
- `br_op`  in  3  op code: NONE=0, JMP=1, BEQ=2, BNE=3, CALL=4, RET=5; 6–7 reserved, treated as NONE
- `lut_idx`  in  4  destination LUT index for JMP/BEQ/BNE/CALL
- `link_idx`  in  4  return LUT index pushed by CALL
- `zero_flag`  in  1  ALU zero flag, valid with `op_valid`
- `absjump_en`  out  1  to PC: load `target` on next edge
- `target`  out  D  `{idx, (D-4)'b0}`
- `flush`  out  1  squash the instruction currently in decode
- `fault`  out  1  sticky stack overflow/underflow
- `depth`  out  $clog2(DEPTH+1)  current stack occupancy

## Operation
- States: RUN, REDIRECT, FAULT. All outputs are registered.
- RUN: an op is *taken* when `op_valid` is high and any of the following holds:
  - JMP;
  - BEQ with `zero_flag`=1;
  - BNE with `zero_flag`=0;
  - CALL with `depth`<DEPTH;
  - RET with `depth`>0.
- Taken op: next state REDIRECT, `target` ← `{idx,0}`, where idx is `lut_idx` for JMP/BEQ/BNE/CALL and the popped top-of-stack for RET.
- Stack updates on a taken op:
  - CALL pushes `link_idx`.
  - RET pops.
- Untaken BEQ/BNE, NONE, reserved ops, or `op_valid`=0: remain in RUN with no outputs asserted.
- CALL with `depth`==DEPTH: next state FAULT, no push, no jump.
- RET with `depth`==0: next state FAULT, no pop, no jump.
- REDIRECT (exactly one cycle): `absjump_en`=1, `flush`=1, `target` held. Any op presented this cycle is ignored regardless of `op_valid`, because that instruction is the squashed fall-through fetch. Next state is RUN unconditionally.
- FAULT: `fault`=1, `absjump_en`=0, `flush`=1 every cycle. Inputs are ignored and the stack is frozen. Only `reset` exits.
- Stack is LIFO. Entries are 4 bits. Pointer arithmetic never wraps; overflow and underflow are caught before the pointer moves.

## Timing
- An op sampled at the edge ending cycle N → `absjump_en`/`target`/`flush` high throughout N+1 → the PC loads on the edge ending N+1 → the new instruction is in decode at N+2.
- Branch penalty: one squashed slot per taken op. Back-to-back taken ops are impossible by construction.
- `depth` updates on the same edge that enters REDIRECT. A CALL in cycle N shows `depth`+1 during N+1.
- Reset (asynchronous, any state, including mid-REDIRECT): state=RUN, `absjump_en`=0, `target`=0, `flush`=0, `fault`=0, `depth`=0, stack contents cleared. The first edge after reset deassertion may sample an op.
- No combinational path from any input to any output.

## Structure
- `branch_pkg` contains:
  - `br_op_t` enum for the op codes;
  - `br_state_t` enum (RUN, REDIRECT, FAULT);
  - `LUT_IDX_W`=4;
  - a target-packing function `{idx, zeros}` parameterised on D.
- Sub-module `ret_stack #(DEPTH)`: push/pop/top/depth/full/empty, with asynchronous reset.
- `branch_unit` owns the FSM and output registers.

## Test plan
- Reset → JMP with `lut_idx`=5 in cycle 1 → cycle 2: `absjump_en`=1, `flush`=1, `target`=10'b0101000000; cycle 3: both deasserted.
- BEQ `lut_idx`=3: with `zero_flag`=0 → no assertion ever; then with `zero_flag`=1 → `target`=10'b0011000000 for one cycle. BNE mirrored.
- CALL `lut_idx`=7, `link_idx`=2 → `target`=0x1C0, `depth`=1; later RET → `target`=0x080, `depth`=0. Nested CALLs with links 1,2,3 followed by three RETs → targets for indices 3,2,1 in that order.
- JMP held valid for two consecutive cycles → only one redirect; the second-cycle op is ignored during REDIRECT.
- RET at `depth`=0 → next cycle `fault`=1, `flush`=1, `absjump_en`=0, and these persist. DEPTH+1 CALLs → fault on the (DEPTH+1)th with `depth` frozen at DEPTH.
- Assert `reset` asynchronously mid-REDIRECT and mid-FAULT → all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution unit and its return stack.
package branch_pkg;

  localparam int LUT_IDX_W = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JMP  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } br_op_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FAULT    = 2'd2
  } br_state_t;

  // Places a jump-LUT index in the top LUT_IDX_W bits of a d-bit target, zeros below.
  function automatic logic [31:0] pack_target(input logic [LUT_IDX_W-1:0] idx, input int d);
    pack_target = 32'(idx) << (d - LUT_IDX_W);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return LUT indices; push/pop are ignored when full/empty so the pointer never wraps.
module ret_stack
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [LUT_IDX_W-1:0]         push_data,
  output logic [LUT_IDX_W-1:0]         top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [LUT_IDX_W-1:0] mem_q [DEPTH];
  logic [DW-1:0]        depth_q;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  assign wr_ptr = depth_q[AW-1:0];
  assign rd_ptr = AW'(depth_q - DW'(1));
  assign top    = mem_q[rd_ptr];
  assign depth  = depth_q;
  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !full) begin
      mem_q[wr_ptr] <= push_data;
      depth_q       <= depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Resolves decoded control-flow ops into a registered PC redirect, squashing the
// fall-through fetch and latching a sticky fault on return-stack misuse.
module branch_unit
  import branch_pkg::*;
#(
  parameter int D     = 10,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        op_valid,
  input  logic [2:0]                  br_op,
  input  logic [LUT_IDX_W-1:0]        lut_idx,
  input  logic [LUT_IDX_W-1:0]        link_idx,
  input  logic                        zero_flag,
  output logic                        absjump_en,
  output logic [D-1:0]                target,
  output logic                        flush,
  output logic                        fault,
  output logic [$clog2(DEPTH+1)-1:0]  depth
);

  br_state_t            state_q, state_d;
  logic [D-1:0]         target_q, target_d;
  logic                 absjump_q, flush_q, fault_q;
  logic                 push, pop;
  logic [LUT_IDX_W-1:0] stk_top;
  logic                 stk_full, stk_empty;

  ret_stack #(.DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (link_idx),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Ops are only evaluated in RUN; the op seen during REDIRECT is the squashed fetch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      RUN: begin
        if (op_valid) begin
          case (br_op)
            OP_JMP: begin
              state_d  = REDIRECT;
              target_d = D'(pack_target(lut_idx, D));
            end
            OP_BEQ: if (zero_flag) begin
              state_d  = REDIRECT;
              target_d = D'(pack_target(lut_idx, D));
            end
            OP_BNE: if (!zero_flag) begin
              state_d  = REDIRECT;
              target_d = D'(pack_target(lut_idx, D));
            end
            OP_CALL: begin
              if (!stk_full) begin
                state_d  = REDIRECT;
                push     = 1'b1;
                target_d = D'(pack_target(lut_idx, D));
              end else begin
                state_d = FAULT;
              end
            end
            OP_RET: begin
              if (!stk_empty) begin
                state_d  = REDIRECT;
                pop      = 1'b1;
                target_d = D'(pack_target(stk_top, D));
              end else begin
                state_d = FAULT;
              end
            end
            default: state_d = RUN;
          endcase
        end
      end
      REDIRECT: state_d = RUN;
      FAULT:    state_d = FAULT;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      target_q  <= '0;
      absjump_q <= 1'b0;
      flush_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      absjump_q <= (state_d == REDIRECT);
      flush_q   <= (state_d == REDIRECT) || (state_d == FAULT);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign absjump_en = absjump_q;
  assign target     = target_q;
  assign flush      = flush_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: jumps, branches, call/return nesting,
// redirect squashing, stack faults and asynchronous reset.
module tb_branch_unit;

  localparam int D     = 10;
  localparam int DEPTH = 4;

  localparam logic [2:0] NONE = 3'd0, JMP = 3'd1, BEQ = 3'd2, BNE = 3'd3,
                         CALL = 3'd4, RET = 3'd5, RSVD = 3'd6;

  logic         clk = 1'b0;
  logic         reset;
  logic         opValid;
  logic [2:0]   brOp;
  logic [3:0]   lutIdx;
  logic [3:0]   linkIdx;
  logic         zeroFlag;
  logic         absjumpEn;
  logic [D-1:0] target;
  logic         flush;
  logic         fault;
  logic [2:0]   depth;

  int checks = 0;
  int errors = 0;

  branch_unit #(.D(D), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (opValid),
    .br_op      (brOp),
    .lut_idx    (lutIdx),
    .link_idx   (linkIdx),
    .zero_flag  (zeroFlag),
    .absjump_en (absjumpEn),
    .target     (target),
    .flush      (flush),
    .fault      (fault),
    .depth      (depth)
  );

  always #5 clk = ~clk;

  // Drives one op, lets the edge sample it, then settles 1 time unit past the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [3:0] lut,
                               input logic [3:0] link, input logic z);
    opValid  = v;
    brOp     = op;
    lutIdx   = lut;
    linkIdx  = link;
    zeroFlag = z;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eAbs, input logic eFlush,
                             input logic eFault, input logic chkT, input logic [D-1:0] eT,
                             input logic [2:0] eDepth);
    checks++;
    assert (absjumpEn === eAbs) else begin
      errors++;
      $error("FAIL %s absjump_en observed %0b expected %0b", tag, absjumpEn, eAbs);
    end
    checks++;
    assert (flush === eFlush) else begin
      errors++;
      $error("FAIL %s flush observed %0b expected %0b", tag, flush, eFlush);
    end
    checks++;
    assert (fault === eFault) else begin
      errors++;
      $error("FAIL %s fault observed %0b expected %0b", tag, fault, eFault);
    end
    checks++;
    assert (depth === eDepth) else begin
      errors++;
      $error("FAIL %s depth observed %0d expected %0d", tag, depth, eDepth);
    end
    if (chkT) begin
      checks++;
      assert (target === eT) else begin
        errors++;
        $error("FAIL %s target observed 0x%0h expected 0x%0h", tag, target, eT);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; opValid = 1'b0; brOp = NONE; lutIdx = '0; linkIdx = '0; zeroFlag = 1'b0;
    #12;
    checkOutput("reset", 0, 0, 0, 1, 10'h000, 0);
    reset = 1'b0;

    applyStimulus(1, JMP, 4'd5, 4'd0, 0);  checkOutput("jmp5", 1, 1, 0, 1, 10'h140, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("jmp5_after", 0, 0, 0, 0, 10'h000, 0);

    applyStimulus(1, BEQ, 4'd3, 4'd0, 0);  checkOutput("beq_nt", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("beq_nt_after", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(1, BEQ, 4'd3, 4'd0, 1);  checkOutput("beq_t", 1, 1, 0, 1, 10'h0C0, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("beq_t_after", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(1, BNE, 4'd3, 4'd0, 1);  checkOutput("bne_nt", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(1, BNE, 4'd9, 4'd0, 0);  checkOutput("bne_t", 1, 1, 0, 1, 10'h240, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("bne_t_after", 0, 0, 0, 0, 10'h000, 0);

    applyStimulus(1, RSVD, 4'd6, 4'd0, 0); checkOutput("reserved", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(1, NONE, 4'd6, 4'd0, 0); checkOutput("none", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(0, JMP, 4'd6, 4'd0, 0);  checkOutput("jmp_invalid", 0, 0, 0, 0, 10'h000, 0);

    applyStimulus(1, CALL, 4'd7, 4'd2, 0); checkOutput("call7", 1, 1, 0, 1, 10'h1C0, 1);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("call7_after", 0, 0, 0, 0, 10'h000, 1);
    applyStimulus(1, RET, 4'd0, 4'd0, 0);  checkOutput("ret2", 1, 1, 0, 1, 10'h080, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0); checkOutput("ret2_after", 0, 0, 0, 0, 10'h000, 0);

    applyStimulus(1, CALL, 4'd8, 4'd1, 0);  checkOutput("ncall1", 1, 1, 0, 1, 10'h200, 1);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    applyStimulus(1, CALL, 4'd9, 4'd2, 0);  checkOutput("ncall2", 1, 1, 0, 1, 10'h240, 2);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    applyStimulus(1, CALL, 4'd10, 4'd3, 0); checkOutput("ncall3", 1, 1, 0, 1, 10'h280, 3);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    applyStimulus(1, RET, 4'd0, 4'd0, 0);   checkOutput("nret3", 1, 1, 0, 1, 10'h0C0, 2);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    applyStimulus(1, RET, 4'd0, 4'd0, 0);   checkOutput("nret2", 1, 1, 0, 1, 10'h080, 1);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    applyStimulus(1, RET, 4'd0, 4'd0, 0);   checkOutput("nret1", 1, 1, 0, 1, 10'h040, 0);
    applyStimulus(0, NONE, 4'd0, 4'd0, 0);  checkOutput("nret_after", 0, 0, 0, 0, 10'h000, 0);

    // The op held into the REDIRECT cycle must be dropped, including a CALL's push.
    applyStimulus(1, JMP, 4'd12, 4'd0, 0);  checkOutput("hold1", 1, 1, 0, 1, 10'h300, 0);
    applyStimulus(1, JMP, 4'd12, 4'd0, 0);  checkOutput("hold2", 0, 0, 0, 0, 10'h000, 0);
    applyStimulus(1, JMP, 4'd1, 4'd0, 0);   checkOutput("squash_jmp", 1, 1, 0, 1, 10'h040, 0);
    applyStimulus(1, CALL, 4'd2, 4'd5, 0);  checkOutput("squash_call", 0, 0, 0, 0, 10'h000, 0);

    applyStimulus(1, JMP, 4'd4, 4'd0, 0);   checkOutput("pre_rst_redir", 1, 1, 0, 1, 10'h100, 0);
    #2 reset = 1'b1;
    #1 checkOutput("rst_mid_redirect", 0, 0, 0, 1, 10'h000, 0);
    #2 reset = 1'b0;

    applyStimulus(1, RET, 4'd0, 4'd0, 0);   checkOutput("underflow", 0, 1, 1, 0, 10'h000, 0);
    applyStimulus(1, JMP, 4'd3, 4'd0, 0);   checkOutput("fault_jmp", 0, 1, 1, 0, 10'h000, 0);
    applyStimulus(1, CALL, 4'd3, 4'd3, 0);  checkOutput("fault_call", 0, 1, 1, 0, 10'h000, 0);
    #2 reset = 1'b1;
    #1 checkOutput("rst_mid_fault", 0, 0, 0, 1, 10'h000, 0);
    #2 reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, CALL, 4'd1, 4'(i), 0);
      checkOutput("fill", 1, 1, 0, 1, 10'h040, 3'(i + 1));
      applyStimulus(0, NONE, 4'd0, 4'd0, 0);
    end
    applyStimulus(1, CALL, 4'd1, 4'd9, 0);  checkOutput("overflow", 0, 1, 1, 0, 10'h000, 4);
    applyStimulus(1, RET, 4'd0, 4'd0, 0);   checkOutput("overflow_hold", 0, 1, 1, 0, 10'h000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
